// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and default widths for the single-port memory arbiter
// that sits between the rvcpu fetch and load/store paths.
package mem_port_arbiter_pkg;

  localparam int DEF_ADDR_W   = 64;
  localparam int DEF_DATA_W   = 64;
  localparam int DEF_MAX_WAIT = 4;

  // Wide enough for the largest legal MAX_WAIT (15).
  localparam int STARVE_W = 4;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } arb_owner_e;

  function automatic logic [STARVE_W-1:0] starve_next(
    input logic [STARVE_W-1:0] cnt,
    input logic [STARVE_W-1:0] max_cnt
  );
    return (cnt == max_cnt) ? cnt : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_prio.sv
// Combinational lsu-first priority pick with a starvation counter that
// forces the fetch path through after MAX_WAIT consecutive losses.
module arb_prio_starve
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                arb_en,
  input  logic                if_valid,
  input  logic                ls_valid,
  output logic                grant_if,
  output logic                grant_ls,
  output logic [STARVE_W-1:0] starve_cnt
);

  localparam logic [STARVE_W-1:0] MAX_CNT = STARVE_W'(MAX_WAIT);

  logic starved;

  assign starved  = (starve_cnt == MAX_CNT);
  assign grant_ls = arb_en && ls_valid && !(if_valid && starved);
  assign grant_if = arb_en && if_valid && !grant_ls;

  // Only lsu wins that actually blocked a waiting ifu count as losses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (grant_if) begin
      starve_cnt <= '0;
    end else if (grant_ls && if_valid) begin
      starve_cnt <= starve_next(starve_cnt, MAX_CNT);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between ifu and lsu with a single outstanding
// transaction: accept, issue, await response, route it to its owner.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_resp_valid,
  output logic [DATA_W-1:0]   if_resp_data,

  input  logic                ls_req_valid,
  output logic                ls_req_ready,
  input  logic [ADDR_W-1:0]   ls_req_addr,
  input  logic                ls_req_wen,
  input  logic [DATA_W-1:0]   ls_req_wdata,
  input  logic [DATA_W/8-1:0] ls_req_wmask,
  output logic                ls_resp_valid,
  output logic [DATA_W-1:0]   ls_resp_data,

  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_wen,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_data,

  output logic                busy
);

  arb_state_e            state_q, state_d;
  arb_owner_e            owner_q;
  logic [ADDR_W-1:0]     hold_addr;
  logic                  hold_wen;
  logic [DATA_W-1:0]     hold_wdata;
  logic [DATA_W/8-1:0]   hold_wmask;

  logic                  arb_en;
  logic                  grant_if;
  logic                  grant_ls;
  logic                  accept;
  logic [STARVE_W-1:0]   starve_cnt;

  // Gating with rst keeps both readys low while reset is held.
  assign arb_en = rst && (state_q == ARB_IDLE);
  assign accept = grant_if || grant_ls;

  arb_prio_starve #(
    .MAX_WAIT (MAX_WAIT)
  ) u_prio (
    .clk        (clk),
    .rst        (rst),
    .arb_en     (arb_en),
    .if_valid   (if_req_valid),
    .ls_valid   (ls_req_valid),
    .grant_if   (grant_if),
    .grant_ls   (grant_ls),
    .starve_cnt (starve_cnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
      owner_q <= OWN_IF;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q <= grant_ls ? OWN_LS : OWN_IF;
      end
    end
  end

  // Fetches are always reads, so the write fields are forced to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_addr  <= '0;
      hold_wen   <= 1'b0;
      hold_wdata <= '0;
      hold_wmask <= '0;
    end else if (accept) begin
      hold_addr  <= grant_ls ? ls_req_addr : if_req_addr;
      hold_wen   <= grant_ls && ls_req_wen;
      hold_wdata <= grant_ls ? ls_req_wdata : '0;
      hold_wmask <= grant_ls ? ls_req_wmask : '0;
    end
  end

  always_comb begin
    state_d       = state_q;
    if_req_ready  = 1'b0;
    ls_req_ready  = 1'b0;
    mem_req_valid = 1'b0;
    if_resp_valid = 1'b0;
    ls_resp_valid = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if_req_ready = grant_if;
        ls_req_ready = grant_ls;
        if (accept) state_d = ARB_REQ;
      end
      ARB_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = ARB_RESP;
      end
      ARB_RESP: begin
        if_resp_valid = mem_resp_valid && (owner_q == OWN_IF);
        ls_resp_valid = mem_resp_valid && (owner_q == OWN_LS);
        if (mem_resp_valid) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign mem_req_addr  = hold_addr;
  assign mem_req_wen   = hold_wen;
  assign mem_req_wdata = hold_wdata;
  assign mem_req_wmask = hold_wmask;

  assign if_resp_data = if_resp_valid ? mem_resp_data : '0;
  assign ls_resp_data = ls_resp_valid ? mem_resp_data : '0;
  assign busy         = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected memory requests and
// routed responses are queued when stimulus is driven and compared on output.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid, if_req_ready, if_resp_valid;
  logic [63:0] if_req_addr, if_resp_data;
  logic        ls_req_valid, ls_req_ready, ls_req_wen, ls_resp_valid;
  logic [63:0] ls_req_addr, ls_req_wdata, ls_resp_data;
  logic [7:0]  ls_req_wmask;
  logic        mem_req_valid, mem_req_ready, mem_req_wen, mem_resp_valid;
  logic [63:0] mem_req_addr, mem_req_wdata, mem_resp_data;
  logic [7:0]  mem_req_wmask;
  logic        busy;

  typedef struct packed {
    logic        owner;
    logic [63:0] addr;
    logic        wen;
    logic [63:0] wdata;
    logic [7:0]  wmask;
  } req_t;

  typedef struct packed {
    logic        owner;
    logic [63:0] data;
  } rsp_t;

  req_t exp_q[$];
  rsp_t rsp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_addr(ls_req_addr),
    .ls_req_wen(ls_req_wen), .ls_req_wdata(ls_req_wdata), .ls_req_wmask(ls_req_wmask),
    .ls_resp_valid(ls_resp_valid), .ls_resp_data(ls_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .busy(busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_if(input logic [63:0] addr);
    exp_q.push_back('{owner: 1'b0, addr: addr, wen: 1'b0, wdata: 64'h0, wmask: 8'h0});
  endtask

  task automatic push_ls();
    exp_q.push_back('{owner: 1'b1, addr: ls_req_addr, wen: ls_req_wen,
                      wdata: ls_req_wdata, wmask: ls_req_wmask});
  endtask

  // Memory side: called one step after an accept edge (arbiter in REQ).
  task automatic serve_mem(input int stall, input logic [63:0] rdata);
    req_t e;
    rsp_t r;
    if (exp_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL sb_empty: got no expected request, required one queued");
      return;
    end
    e = exp_q.pop_front();
    mem_req_ready = (stall == 0);
    for (int i = 0; i < stall; i++) begin
      #1;
      n_checks++;
      if ({mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
           if_req_ready, ls_req_ready, busy} !==
          {1'b1, e.addr, e.wen, e.wdata, e.wmask, 1'b0, 1'b0, 1'b1}) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got v=%b a=%h w=%b d=%h m=%h rdy=%b%b busy=%b, required v=1 a=%h w=%b d=%h m=%h rdy=00 busy=1",
                 i, mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
                 if_req_ready, ls_req_ready, busy, e.addr, e.wen, e.wdata, e.wmask);
      end
      step();
    end
    mem_req_ready = 1'b1;
    #1;
    n_checks++;
    if ({mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask} !==
        {1'b1, e.addr, e.wen, e.wdata, e.wmask}) begin
      n_fail++;
      $display("FAIL mem_req: got v=%b a=%h w=%b d=%h m=%h, required v=1 a=%h w=%b d=%h m=%h",
               mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
               e.addr, e.wen, e.wdata, e.wmask);
    end
    step();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = rdata;
    rsp_q.push_back('{owner: e.owner, data: rdata});
    #1;
    r = rsp_q.pop_front();
    n_checks++;
    if (r.owner) begin
      if ({ls_resp_valid, ls_resp_data, if_resp_valid, if_resp_data} !== {1'b1, r.data, 1'b0, 64'h0}) begin
        n_fail++;
        $display("FAIL ls_route: got ls=%b/%h if=%b/%h, required ls=1/%h if=0/0",
                 ls_resp_valid, ls_resp_data, if_resp_valid, if_resp_data, r.data);
      end
    end else begin
      if ({if_resp_valid, if_resp_data, ls_resp_valid, ls_resp_data} !== {1'b1, r.data, 1'b0, 64'h0}) begin
        n_fail++;
        $display("FAIL if_route: got if=%b/%h ls=%b/%h, required if=1/%h ls=0/0",
                 if_resp_valid, if_resp_data, ls_resp_valid, ls_resp_data, r.data);
      end
    end
    step();
    mem_resp_valid = 1'b0;
    mem_resp_data  = 64'h0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    if_req_valid = 0; if_req_addr = 0;
    ls_req_valid = 0; ls_req_addr = 0; ls_req_wen = 0; ls_req_wdata = 0; ls_req_wmask = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0;
    step(); step();
    if_req_valid = 1'b1; ls_req_valid = 1'b1; mem_resp_valid = 1'b1;
    #1;
    n_checks++;
    if ({if_req_ready, ls_req_ready, mem_req_valid, if_resp_valid, ls_resp_valid, busy,
         mem_req_addr, dut.u_prio.starve_cnt} !== {6'b0, 64'h0, 4'h0}) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b%b mv=%b rv=%b%b busy=%b a=%h cnt=%0d, required all 0",
               if_req_ready, ls_req_ready, mem_req_valid, if_resp_valid, ls_resp_valid, busy,
               mem_req_addr, dut.u_prio.starve_cnt);
    end
    if_req_valid = 0; ls_req_valid = 0; mem_resp_valid = 0;
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_ifu_only();
    if_req_valid = 1'b1; if_req_addr = 64'h8000_0000; mem_req_ready = 1'b1;
    #1;
    n_checks++;
    if ({if_req_ready, ls_req_ready, mem_req_valid} !== 3'b100) begin
      n_fail++;
      $display("FAIL ifu_accept: got if_rdy=%b ls_rdy=%b mv=%b, required 1 0 0",
               if_req_ready, ls_req_ready, mem_req_valid);
    end
    push_if(64'h8000_0000);
    step();
    if_req_valid = 1'b0;
    serve_mem(0, 64'h0010_0073);
    n_checks++;
    if ({busy, if_resp_valid, ls_resp_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL ifu_done: got busy=%b if_rv=%b ls_rv=%b, required 000", busy, if_resp_valid, ls_resp_valid);
    end
  endtask

  task automatic test_both_store();
    if_req_valid = 1'b1; if_req_addr = 64'h8000_0040;
    ls_req_valid = 1'b1; ls_req_addr = 64'h8000_1000; ls_req_wen = 1'b1;
    ls_req_wdata = 64'h1234; ls_req_wmask = 8'h0F;
    #1;
    n_checks++;
    if ({ls_req_ready, if_req_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL both_ls_wins: got ls_rdy=%b if_rdy=%b, required 1 0", ls_req_ready, if_req_ready);
    end
    push_ls();
    step();
    ls_req_valid = 1'b0;
    serve_mem(0, 64'hDEAD);
    #1;
    n_checks++;
    if ({if_req_ready, ls_req_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL both_if_next: got if_rdy=%b ls_rdy=%b, required 1 0", if_req_ready, ls_req_ready);
    end
    push_if(64'h8000_0040);
    step();
    if_req_valid = 1'b0;
    serve_mem(0, 64'h0000_0013);
  endtask

  task automatic test_starvation();
    logic       exp_ls;
    logic [3:0] exp_cnt;
    logic [3:0] cnt_seq [6] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1};
    if_req_valid = 1'b1; if_req_addr = 64'h8000_0100;
    ls_req_valid = 1'b1; ls_req_addr = 64'h8000_2000; ls_req_wen = 1'b0;
    ls_req_wdata = 64'h0; ls_req_wmask = 8'h0;
    for (int k = 0; k < 6; k++) begin
      exp_ls  = (k != 4);
      exp_cnt = cnt_seq[k];
      #1;
      n_checks++;
      if ({ls_req_ready, if_req_ready} !== {exp_ls, ~exp_ls}) begin
        n_fail++;
        $display("FAIL starve_grant[%0d]: got ls_rdy=%b if_rdy=%b, required %b %b",
                 k, ls_req_ready, if_req_ready, exp_ls, ~exp_ls);
      end
      if (exp_ls) push_ls(); else push_if(64'h8000_0100);
      step();
      n_checks++;
      if (dut.u_prio.starve_cnt !== exp_cnt) begin
        n_fail++;
        $display("FAIL starve_cnt[%0d]: got %0d, required %0d", k, dut.u_prio.starve_cnt, exp_cnt);
      end
      serve_mem(0, 64'h100 + 64'(k));
    end
    if_req_valid = 1'b0; ls_req_valid = 1'b0;
    step();
  endtask

  task automatic test_stall();
    ls_req_valid = 1'b1; ls_req_addr = 64'h8000_3008; ls_req_wen = 1'b1;
    ls_req_wdata = 64'hCAFE_F00D_0BAD_BEEF; ls_req_wmask = 8'hF0;
    #1;
    n_checks++;
    if (ls_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_accept: got ls_rdy=%b, required 1", ls_req_ready);
    end
    push_ls();
    step();
    ls_req_valid = 1'b0; ls_req_addr = 64'h0; ls_req_wdata = 64'h0; ls_req_wmask = 8'h0;
    if_req_valid = 1'b1; if_req_addr = 64'h8000_0200;
    serve_mem(5, 64'h0);
    #1;
    n_checks++;
    if (if_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_if_after: got if_rdy=%b, required 1", if_req_ready);
    end
    push_if(64'h8000_0200);
    step();
    if_req_valid = 1'b0;
    serve_mem(0, 64'h0000_0093);
  endtask

  task automatic test_reset_in_resp();
    req_t e;
    if_req_valid = 1'b1; if_req_addr = 64'h8000_0300;
    #1;
    step();
    if_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    e = '{owner: 1'b0, addr: 64'h8000_0300, wen: 1'b0, wdata: 64'h0, wmask: 8'h0};
    #1;
    n_checks++;
    if ({mem_req_valid, mem_req_addr} !== {1'b1, e.addr}) begin
      n_fail++;
      $display("FAIL rstresp_req: got v=%b a=%h, required v=1 a=%h", mem_req_valid, mem_req_addr, e.addr);
    end
    step();
    mem_req_ready = 1'b0;
    rst = 1'b0;
    if_req_valid = 1'b1; ls_req_valid = 1'b1;
    #1;
    n_checks++;
    if ({if_req_ready, ls_req_ready, mem_req_valid, if_resp_valid, ls_resp_valid, busy,
         mem_req_addr} !== {6'b0, 64'h0}) begin
      n_fail++;
      $display("FAIL rstresp_during: got rdy=%b%b mv=%b rv=%b%b busy=%b a=%h, required all 0",
               if_req_ready, ls_req_ready, mem_req_valid, if_resp_valid, ls_resp_valid, busy, mem_req_addr);
    end
    step();
    if_req_valid = 1'b0; ls_req_valid = 1'b0;
    rst = 1'b1;
    mem_resp_valid = 1'b1; mem_resp_data = 64'h5555;
    #1;
    n_checks++;
    if ({if_resp_valid, ls_resp_valid, if_resp_data, ls_resp_data, busy} !== {2'b0, 128'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL rstresp_late: got rv=%b%b d=%h/%h busy=%b, required all 0",
               if_resp_valid, ls_resp_valid, if_resp_data, ls_resp_data, busy);
    end
    step();
    mem_resp_valid = 1'b0; mem_resp_data = 64'h0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rstresp_idle: got busy=%b, required 0", busy);
    end
  endtask

  task automatic test_stray();
    mem_resp_valid = 1'b1; mem_resp_data = 64'h7777;
    #1;
    n_checks++;
    if ({if_resp_valid, ls_resp_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL stray_idle: got rv=%b%b, required 00", if_resp_valid, ls_resp_valid);
    end
    step();
    mem_resp_valid = 1'b0;
    ls_req_valid = 1'b1; ls_req_addr = 64'h8000_4000; ls_req_wen = 1'b0;
    ls_req_wdata = 64'h0; ls_req_wmask = 8'h0;
    #1;
    n_checks++;
    if ({busy, ls_req_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL stray_accept: got busy=%b ls_rdy=%b, required 0 1", busy, ls_req_ready);
    end
    push_ls();
    step();
    ls_req_valid = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 64'h8888;
    #1;
    n_checks++;
    if ({if_resp_valid, ls_resp_valid, mem_req_valid} !== 3'b001) begin
      n_fail++;
      $display("FAIL stray_req: got rv=%b%b mv=%b, required 00 1", if_resp_valid, ls_resp_valid, mem_req_valid);
    end
    step();
    mem_resp_valid = 1'b0; mem_resp_data = 64'h0;
    serve_mem(0, 64'h0000_ABCD);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_ifu_only();
    test_both_store();
    test_starvation();
    test_stall();
    test_reset_in_resp();
    test_stray();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory port between the instruction fetch path (ifu) and the load/store path (lsu) of rvcpu, so the core can move to a one-port memory model.
- Supports one outstanding transaction at a time: accept a request, issue it on the memory port, wait for the response, route the response back to its owner.
- lsu has fixed priority. A starvation counter guarantees that ifu is granted after at most MAX_WAIT consecutive losses.

Parameters:
- ADDR_W, 64, address width
- DATA_W, 64, data width; the write mask is DATA_W/8 bits wide
- MAX_WAIT, 4, consecutive lost arbitrations after which ifu is forced to win (range 1..15)

Ports:
- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  asynchronous reset, active-low
- if_req_valid  in  1  ifu fetch request
- if_req_ready  out  1  ifu request accepted this cycle
- if_req_addr  in  ADDR_W  fetch address
- if_resp_valid  out  1  fetch data valid (single-cycle pulse)
- if_resp_data  out  DATA_W  fetch data
- ls_req_valid  in  1  lsu request
- ls_req_ready  out  1  lsu request accepted this cycle
- ls_req_addr  in  ADDR_W  lsu address
- ls_req_wen  in  1  1 = store, 0 = load
- ls_req_wdata  in  DATA_W  store data
- ls_req_wmask  in  DATA_W/8  byte strobes
- ls_resp_valid  out  1  load data or store acknowledge (single-cycle pulse)
- ls_resp_data  out  DATA_W  load data
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts the request
- mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask  out  as the lsu fields  registered request fields
- mem_resp_valid  in  1  memory response
- mem_resp_data  in  DATA_W  memory read data
- busy  out  1  state is not IDLE

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE, owner = IF, starve_cnt = 0.
  - All holding registers are cleared to 0.
  - All valid and ready outputs are 0.
  - An in-flight transaction is abandoned; a later mem_resp_valid arriving in IDLE is ignored.
- States: IDLE, REQ, RESP (2-bit encoding).
- IDLE, arbitration is combinational in the same cycle:
  - If only one requester is valid, it wins.
  - If both are valid, lsu wins unless starve_cnt == MAX_WAIT; in that case ifu wins.
  - The winner's *_req_ready = 1. The loser's ready = 0.
  - On the handshake edge: latch addr, wen, wdata and wmask (ifu forces wen = 0, wmask = 0, wdata = 0), set owner, go to REQ.
- REQ:
  - mem_req_valid = 1, driven from the holding registers.
  - Registers hold stable until mem_req_ready; on mem_req_ready go to RESP.
- RESP:
  - Wait for mem_resp_valid.
  - The owner's *_resp_valid = mem_resp_valid, combinational, single cycle.
  - *_resp_data = mem_resp_data.
  - On the response edge go to IDLE.
- *_req_ready is 0 in REQ and RESP. A new request can be accepted no earlier than the cycle after the response.
- mem_resp_valid outside RESP is ignored. Memory must not respond in the same cycle it accepts a request.
- Response data outputs are 0 whenever the corresponding resp_valid is 0.
- Minimum latency, ready memory: accept in cycle 0, mem_req_valid in cycle 1, response no earlier than cycle 2, next accept in cycle 3.
- starve_cnt:
  - Increments (saturating at MAX_WAIT) on each lsu grant while if_req_valid = 1.
  - Cleared on each ifu grant.
  - Otherwise unchanged.
- Requesters must hold valid and fields stable until ready. The arbiter does not check this.

Decomposition:
- Shared package or defines file: state encoding (ARB_IDLE/ARB_REQ/ARB_RESP), owner encoding (OWN_IF/OWN_LS), default widths.
- One natural sub-module, arb_prio_starve: the combinational priority pick plus the starve_cnt register. The FSM and datapath stay in mem_port_arbiter.

Test Plan:
- ifu only, addr 0x80000000, mem_req_ready = 1, response one cycle later with data 0x00100073 -> if_req_ready in cycle 0, mem_req_valid in cycle 1 with addr 0x80000000 and wen = 0, if_resp_valid with data 0x00100073, ls_resp_valid never asserted.
- Both valid in the same cycle, lsu store addr 0x80001000, wdata 0x1234, wmask 0x0F -> lsu granted, memory sees wen = 1, wdata 0x1234, wmask 0x0F; ifu granted on the next IDLE cycle.
- lsu continuously valid, ifu continuously valid, MAX_WAIT = 4 -> grant order LS, LS, LS, LS, IF, LS...; starve_cnt observed 1, 2, 3, 4, 0.
- mem_req_ready held low for 5 cycles -> mem_req_valid and all fields stable for 5 cycles, both upstream readys 0, busy = 1.
- rst pulsed low while in RESP, then mem_resp_valid = 1 arrives in IDLE -> no resp_valid on either side; outputs 0 during reset.
- Stray mem_resp_valid while in IDLE or REQ -> ignored; the real response is still routed to the correct owner.
